// File: rtl/image_ram_arbiter.sv
// Two-requester arbiter for a single-port image RAM: decoder (req1) has priority, filter (req2)
// second; optional starvation guard for the filter is enabled by defining ARB_STARVE_GUARD_EN.
module image_ram_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 17,
  parameter int STARVE_LIMIT  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req1,
  input  logic                     req2,
  input  logic                     lock1,
  input  logic                     lock2,
  input  logic                     we1,
  input  logic                     we2,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [ADDRESS_WIDTH-1:0] addr2,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  input  logic [DATA_WIDTH-1:0]    wdata2,
  output logic                     gnt1,
  output logic                     gnt2,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic [DATA_WIDTH-1:0]    rdata2,
  output logic                     rvalid1,
  output logic                     rvalid2,
  output logic                     ram_ce,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  output logic                     avail2
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK1 = 2'd1,
    LOCK2 = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       rvalid1_q, rvalid1_d;
  logic                       rvalid2_q, rvalid2_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic                       starve_fire;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q, starve_d;

  assign starve_fire = (starve_q == CW'(STARVE_LIMIT));

  // Counts consecutive cycles the filter waits; saturates so it cannot wrap past the limit.
  always_comb begin
    starve_d = '0;
    if (req2 && !gnt2) begin
      starve_d = (starve_q == CW'(STARVE_LIMIT)) ? starve_q : starve_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starve_fire = 1'b0;
`endif

  // Grant decision and next state; the starvation override beats priority and LOCK1.
  always_comb begin
    gnt1    = 1'b0;
    gnt2    = 1'b0;
    state_d = state_q;
    if (!rst) begin
      if (starve_fire && req2) begin
        gnt2    = 1'b1;
        state_d = lock2 ? LOCK2 : IDLE;
      end else begin
        case (state_q)
          LOCK1: begin
            gnt1    = req1;
            state_d = (req1 && lock1) ? LOCK1 : IDLE;
          end
          LOCK2: begin
            gnt2    = req2;
            state_d = (req2 && lock2) ? LOCK2 : IDLE;
          end
          default: begin
            state_d = IDLE;
            if (req1) begin
              gnt1    = 1'b1;
              state_d = lock1 ? LOCK1 : IDLE;
            end else if (req2) begin
              gnt2    = 1'b1;
              state_d = lock2 ? LOCK2 : IDLE;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (gnt1) begin
      addr_d  = addr1;
      wdata_d = wdata1;
    end else if (gnt2) begin
      addr_d  = addr2;
      wdata_d = wdata2;
    end
    rvalid1_d = gnt1 && !we1;
    rvalid2_d = gnt2 && !we2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rvalid1_q <= 1'b0;
      rvalid2_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rvalid1_q <= rvalid1_d;
      rvalid2_q <= rvalid2_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // The RAM bus follows the grant in the same cycle and parks on the last granted access.
  assign ram_ce      = gnt1 || gnt2;
  assign ram_we      = (gnt1 && we1) || (gnt2 && we2);
  assign ram_address = rst ? '0 : addr_d;
  assign ram_wdata   = rst ? '0 : wdata_d;

  // A read issued just before reset must not surface while reset is held.
  assign rvalid1 = rvalid1_q && !rst;
  assign rvalid2 = rvalid2_q && !rst;
  assign rdata1  = ram_rdata;
  assign rdata2  = ram_rdata;

  assign avail2 = !rst && (starve_fire || (!req1 && (state_q != LOCK1)));

endmodule
